// File: rtl/sdhci_reg_arb.sv
// Round-robin arbiter sharing the SD host controller register slave between NumPorts requesters.
// Packing: req = {addr, write, wdata, wstrb, valid} (valid is bit 0); rsp = {rdata, error, ready} (ready is bit 0).
module sdhci_reg_arb #(
    parameter  int NumPorts  = 2,
    parameter  int AddrWidth = 32,
    parameter  int DataWidth = 32,
    localparam int StrbWidth = DataWidth / 8,
    localparam int ReqWidth  = AddrWidth + DataWidth + StrbWidth + 2,
    localparam int RspWidth  = DataWidth + 2,
    localparam int IdxWidth  = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumPorts*ReqWidth-1:0] req_i,
    output logic [NumPorts*RspWidth-1:0] rsp_o,
    output logic [ReqWidth-1:0]          req_o,
    input  logic [RspWidth-1:0]          rsp_i,
    output logic [IdxWidth-1:0]          gnt_o,
    output logic                         busy_o
);

    // state  | meaning
    // IDLE   | arbitrating; winner forwarded combinationally, zero-wait completions stay here
    // LOCKED | grant_q held until the slave answers or the requester drops valid
    typedef enum logic {IDLE, LOCKED} fsm_e;

    fsm_e                fsm_q, fsm_d;
    logic [IdxWidth-1:0] grant_q, grant_d;
    logic [IdxWidth-1:0] ptr_q, ptr_d;

    logic [NumPorts-1:0] valid_vec;
    logic [IdxWidth-1:0] winner;
    logic                any_valid;
    logic [IdxWidth-1:0] sel;
    logic                fwd;
    logic                busy;
    logic                rsp_ready;

    assign rsp_ready = rsp_i[0];

    function automatic logic [IdxWidth-1:0] next_idx(input logic [IdxWidth-1:0] idx);
        if (int'(idx) >= NumPorts - 1) begin
            return '0;
        end
        return IdxWidth'(int'(idx) + 1);
    endfunction

    always_comb begin
        valid_vec = '0;
        for (int p = 0; p < NumPorts; p++) begin
            valid_vec[p] = req_i[p*ReqWidth];
        end
    end

    // Walk downward so the candidate closest to ptr_q is written last and wins.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int k = NumPorts - 1; k >= 0; k--) begin
            if (valid_vec[(int'(ptr_q) + k) % NumPorts]) begin
                winner    = IdxWidth'((int'(ptr_q) + k) % NumPorts);
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        sel     = '0;
        fwd     = 1'b0;
        busy    = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (any_valid) begin
                    sel  = winner;
                    fwd  = 1'b1;
                    busy = 1'b1;
                    if (rsp_ready) begin
                        ptr_d = next_idx(winner);
                    end else begin
                        grant_d = winner;
                        fsm_d   = LOCKED;
                    end
                end
            end
            LOCKED: begin
                sel  = grant_q;
                busy = 1'b1;
                fwd  = valid_vec[grant_q];
                // A withdrawn request abandons the transaction without moving the pointer.
                if (!valid_vec[grant_q]) begin
                    fsm_d = IDLE;
                end else if (rsp_ready) begin
                    ptr_d = next_idx(grant_q);
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held, even though arbitration is combinational.
    always_comb begin
        req_o  = '0;
        rsp_o  = '0;
        gnt_o  = '0;
        busy_o = 1'b0;
        if (!rst_i) begin
            busy_o = busy;
            gnt_o  = sel;
            if (busy) begin
                req_o = req_i[int'(sel)*ReqWidth +: ReqWidth];
            end
            if (fwd) begin
                rsp_o[int'(sel)*RspWidth +: RspWidth] = rsp_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q   <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_sdhci_reg_arb.sv
// Bench for sdhci_reg_arb: vector table for zero-wait arbitration plus hand sequences for locking,
// reset and withdrawal; completions are matched against a scoreboard queue.
module tb_sdhci_reg_arb;
    localparam int NP   = 2;
    localparam int REQW = 70;
    localparam int RSPW = 34;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NP*REQW-1:0]   req_i;
    logic [NP*RSPW-1:0]   rsp_o;
    logic [REQW-1:0]      req_o;
    logic [RSPW-1:0]      rsp_i;
    logic [0:0]           gnt_o;
    logic                 busy_o;

    sdhci_reg_arb #(.NumPorts(NP), .AddrWidth(32), .DataWidth(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .req_i (req_i),
        .rsp_o (rsp_o),
        .req_o (req_o),
        .rsp_i (rsp_i),
        .gnt_o (gnt_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cnt[NP];

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        v0;
        logic        v1;
        logic        rdy;
        logic        err;
        logic [31:0] rdata;
        logic        exp_busy;
        logic        exp_gnt;
        logic        exp_ptr;
    } vec_t;
    vec_t vt[10];

    function automatic logic [REQW-1:0] pack_req(input int p, input logic v);
        if (p == 0) return {32'h0000_0024, 1'b0, 32'h0, 4'h0, v};
        return {32'h0000_0030, 1'b1, 32'h1234_5678, 4'hF, v};
    endfunction

    task automatic drive(input logic v0, input logic v1, input logic rdy, input logic err,
                         input logic [31:0] rdata);
        req_i = {pack_req(1, v1), pack_req(0, v0)};
        rsp_i = {rdata, err, rdy};
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int port, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.port  = port;
        e.rdata = rdata;
        e.err   = err;
        sb.push_back(e);
    endtask

    task automatic observe();
        exp_t e;
        for (int p = 0; p < NP; p++) begin
            if (rsp_o[p*RSPW]) begin
                cnt[p]++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: port %0d got ready, none expected", p);
                end else begin
                    e = sb.pop_front();
                    check("sb_port", 64'(p), 64'(e.port));
                    check("sb_rdata", rsp_o[p*RSPW+2 +: 32], e.rdata);
                    check("sb_error", rsp_o[p*RSPW+1], e.err);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [REQW-1:0] exp_req;
        logic [RSPW-1:0] exp_rsp;

        //              v0    v1    rdy   err   rdata          busy  gnt   ptr after
        vt[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1};
        vt[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h1111_0002, 1'b1, 1'b1, 1'b0};
        vt[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h1111_0003, 1'b1, 1'b0, 1'b1};
        vt[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h1111_0004, 1'b1, 1'b1, 1'b0};
        vt[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h1111_0005, 1'b1, 1'b1, 1'b0};
        vt[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hBAD0_0006, 1'b1, 1'b1, 1'b0};
        vt[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h1111_0007, 1'b1, 1'b0, 1'b1};
        vt[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hBAD0_0008, 1'b1, 1'b0, 1'b1};
        vt[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        cnt[0] = 0;
        cnt[1] = 0;

        // Outputs quiet during reset even with live requests.
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF);
        #3;
        check("rst_req_o", req_o, '0);
        check("rst_rsp_o", rsp_o, '0);
        check("rst_gnt", 64'(gnt_o), 0);
        check("rst_busy", 64'(busy_o), 0);
        tick();
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        #1;
        check("rst_ptr", 64'(dut.ptr_q), 0);

        // Both ports valid, zero-wait slave: grants alternate starting from port0.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 32'hA000_0000 + 32'(i));
            push(i % 2, 32'hA000_0000 + 32'(i), 1'b0);
            #1;
            check("alt_gnt", 64'(gnt_o), 64'(i % 2));
            observe();
            tick();
        end
        check("alt_cnt0", 64'(cnt[0]), 2);
        check("alt_cnt1", 64'(cnt[1]), 2);

        // Zero-wait vector table.
        for (int i = 0; i < 10; i++) begin
            drive(vt[i].v0, vt[i].v1, vt[i].rdy, vt[i].err, vt[i].rdata);
            if (vt[i].exp_busy && vt[i].rdy) push(int'(vt[i].exp_gnt), vt[i].rdata, vt[i].err);
            #1;
            exp_req = vt[i].exp_busy ? pack_req(int'(vt[i].exp_gnt), 1'b1) : '0;
            check("vec_busy", 64'(busy_o), 64'(vt[i].exp_busy));
            check("vec_gnt", 64'(gnt_o), 64'(vt[i].exp_gnt));
            check("vec_req_o", req_o, exp_req);
            for (int p = 0; p < NP; p++) begin
                exp_rsp = (vt[i].exp_busy && int'(vt[i].exp_gnt) == p)
                          ? {vt[i].rdata, vt[i].err, vt[i].rdy} : '0;
                check("vec_rsp", rsp_o[p*RSPW +: RSPW], exp_rsp);
            end
            observe();
            tick();
            check("vec_ptr", 64'(dut.ptr_q), 64'(vt[i].exp_ptr));
            check("vec_fsm", 64'(dut.fsm_q), 0);
        end

        // Wait-state slave while port1 holds the grant; port0 joins mid-way.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        check("ws_busy0", 64'(busy_o), 1);
        check("ws_gnt0", 64'(gnt_o), 1);
        observe();
        tick();
        for (int c = 1; c < 3; c++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            #1;
            check("ws_busy", 64'(busy_o), 1);
            check("ws_gnt", 64'(gnt_o), 1);
            check("ws_rsp0", rsp_o[0 +: RSPW], '0);
            observe();
            tick();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h5A5A_0001);
        push(1, 32'h5A5A_0001, 1'b0);
        #1;
        check("ws_gnt_done", 64'(gnt_o), 1);
        observe();
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h5A5A_0002);
        push(0, 32'h5A5A_0002, 1'b0);
        #1;
        check("ws_next_gnt", 64'(gnt_o), 0);
        observe();
        tick();

        // Reset while locked on port1.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        observe();
        tick();
        check("rm_locked", 64'(dut.fsm_q), 1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        check("rm_gnt_pre", 64'(gnt_o), 1);
        rst = 1'b1;
        #1;
        check("rm_req_valid", 64'(req_o[0]), 0);
        check("rm_busy", 64'(busy_o), 0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'hCAFE_0000);
        #1;
        check("rm_rsp_o", rsp_o, '0);
        observe();
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'hCAFE_0001);
        push(0, 32'hCAFE_0001, 1'b0);
        #1;
        check("rm_first_gnt", 64'(gnt_o), 0);
        observe();
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'hCAFE_0002);
        push(1, 32'hCAFE_0002, 1'b0);
        #1;
        observe();
        tick();
        check("wd_ptr_pre", 64'(dut.ptr_q), 0);

        // Port0 withdraws valid while locked; port1 must be ignored and no response produced.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        observe();
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h7777_7777);
        #1;
        check("wd_busy", 64'(busy_o), 1);
        check("wd_gnt", 64'(gnt_o), 0);
        check("wd_rsp_o", rsp_o, '0);
        observe();
        tick();
        check("wd_fsm", 64'(dut.fsm_q), 0);
        check("wd_ptr", 64'(dut.ptr_q), 0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h7777_0001);
        push(0, 32'h7777_0001, 1'b0);
        #1;
        check("wd_next_gnt", 64'(gnt_o), 0);
        observe();
        tick();

        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check("sb_empty", 64'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
